// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Multiplexed seven-segment scanner. A packed hex value (one nibble per digit)
// is captured into shadow registers once per frame and shown one digit at a
// time on a common-anode display. Each digit slot lasts 2^DIV_BITS cycles. The
// first DEAD_CYCLES cycles of every slot keep all anodes off, so the segment
// pattern of the previous digit does not ghost onto the next one.
//
// Parameters:
//   NUM_DIGITS  - number of multiplexed digits (1..16)
//   DIV_BITS    - log2 of the slot length in clk cycles
//   DEAD_CYCLES - all-anodes-off cycles at the start of each slot
//                 (must be < 2^DIV_BITS)
//
// Ports:
//   clk         - system clock
//   rst         - synchronous, active-high reset
//   en          - display enable; low blanks the display and restarts the scan
//   data        - hex nibbles, digit i = data[4i+3:4i]
//   blank       - bit i high forces digit i dark
//   dp          - bit i high lights the decimal point of digit i
//   seg_n       - active-low segments {dp, g, f, e, d, c, b, a}
//   an_n        - active-low anode select, at most one bit low
//   frame_start - one-cycle pulse, the cycle after the shadow registers load
//
// Build option:
//   SEG_LEADING_ZERO_BLANK_EN - when defined, leading zero digits (nibble 0 and
//   dp clear, scanning from the most significant digit down to digit 1) are
//   blanked when the frame is captured. Digit 0 is never auto-blanked.
// -----------------------------------------------------------------------------
module seg_scan_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int DIV_BITS    = 17,
    parameter int DEAD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [7:0]              seg_n,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic                    frame_start
);

    // A single-digit display still needs a one-bit digit counter.
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [DIV_BITS-1:0] DEAD_LIM   = DIV_BITS'(DEAD_CYCLES);
    localparam logic [DW-1:0]       LAST_DIGIT = DW'(NUM_DIGITS - 1);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Scan counters
    // -------------------------------------------------------------------------
    logic [DIV_BITS-1:0] div_cnt;
    logic [DW-1:0]       digit;
    logic                div_wrap;
    logic                digit_wrap;
    logic                snapshot;

    assign div_wrap   = (div_cnt == '1);
    assign digit_wrap = (digit == LAST_DIGIT);

    // Frame boundary: slot 0 of digit 0. Because en=0 parks both counters at
    // zero, the first enabled cycle after reset or after en rises is always a
    // frame boundary and the shadow registers load immediately.
    assign snapshot = en && (div_cnt == '0) && (digit == '0);

    // NOTE: every clocked process uses non-blocking assignments so that all
    // registers sample the pre-edge values; blocking assignments here would
    // make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= '0;
        end else if (!en) begin
            div_cnt <= '0;
            digit   <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_wrap) begin
                digit <= digit_wrap ? '0 : digit + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Leading-zero suppression, evaluated on the live inputs so the result is
    // captured together with the frame.
    // -------------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] auto_blank;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    always_comb begin : lz_scan
        logic leading;
        // NOTE: every variable written in a combinational block gets a default
        // at the top; a path that leaves it unassigned would infer a latch.
        auto_blank = '0;
        leading    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (data[4*i +: 4] == 4'h0) && !dp[i]) begin
                auto_blank[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign auto_blank = '0;
`endif

    // -------------------------------------------------------------------------
    // Shadow registers: the frame shown on the display. Inputs are only
    // sampled at the frame boundary, so the display never tears mid-scan.
    // -------------------------------------------------------------------------
    logic [4*NUM_DIGITS-1:0] shadow_data;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   shadow_dp;

    // NOTE: the shadow bank is a handful of flops, not a RAM, so it is reset
    // like any other state; a reset that left it X would be visible if the
    // capture were ever delayed past the first lit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_blank <= '0;
            shadow_dp    <= '0;
        end else if (snapshot) begin
            shadow_data  <= data;
            shadow_blank <= blank | auto_blank;
            shadow_dp    <= dp;
        end
    end

    // -------------------------------------------------------------------------
    // Current-digit selection from the shadow bank
    // -------------------------------------------------------------------------
    logic [3:0]            cur_nibble;
    logic                  cur_blank;
    logic                  cur_dp;
    logic [NUM_DIGITS-1:0] an_sel;

    always_comb begin
        cur_nibble = 4'h0;
        cur_blank  = 1'b0;
        cur_dp     = 1'b0;
        an_sel     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(digit) == i) begin
                cur_nibble = shadow_data[4*i +: 4];
                cur_blank  = shadow_blank[i];
                cur_dp     = shadow_dp[i];
                an_sel[i]  = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next output values
    // -------------------------------------------------------------------------
    logic [7:0]            seg_next;
    logic [NUM_DIGITS-1:0] an_next;

    always_comb begin
        seg_next = 8'hFF;
        an_next  = '1;
        if (div_cnt >= DEAD_LIM) begin
            an_next = an_sel;
            // A blanked digit keeps its anode asserted but lights nothing,
            // decimal point included, so brightness of the other digits is
            // unaffected by how many are blanked.
            if (!cur_blank) begin
                seg_next = {~cur_dp, hex7(cur_nibble)};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered outputs: glitch-free pins, one cycle behind the counters.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            seg_n       <= 8'hFF;
            an_n        <= '1;
            frame_start <= 1'b0;
        end else begin
            seg_n       <= seg_next;
            an_n        <= an_next;
            frame_start <= snapshot;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//
// Self-checking bench for seg_scan_display with NUM_DIGITS=4, DIV_BITS=2,
// DEAD_CYCLES=1, plus a single-digit instance sharing the same stimulus.
// Expected outputs for each clock are pushed into a queue as the stimulus for
// that clock is driven and popped and compared one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int DB = 2;
    localparam int DC = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [7:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_start;

    logic [7:0]  seg1_n;
    logic [0:0]  an1_n;
    logic        fs1;

    always #5 clk = ~clk;

    seg_scan_display #(
        .NUM_DIGITS (ND),
        .DIV_BITS   (DB),
        .DEAD_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data),
        .blank      (blank),
        .dp         (dp),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_start(frame_start)
    );

    // Single-digit instance: digit counter must stay at 0 and every slot is a
    // frame boundary.
    seg_scan_display #(
        .NUM_DIGITS (1),
        .DIV_BITS   (DB),
        .DEAD_CYCLES(DC)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .data       (data[3:0]),
        .blank      (blank[0:0]),
        .dp         (dp[0:0]),
        .seg_n      (seg1_n),
        .an_n       (an1_n),
        .frame_start(fs1)
    );

    typedef struct {
        logic [15:0]     data;
        logic [3:0]      blank;
        logic [3:0]      dp;
        logic [3:0][7:0] seg;   // expected seg_n per digit while lit
    } vec_t;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] an;
        logic       fs;
        logic [7:0] seg1;
        logic       an1;
        logic       fs1;
        logic       chk1;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic exp_t off_exp();
        exp_t m;
        m.seg  = 8'hFF;
        m.an   = 4'hF;
        m.fs   = 1'b0;
        m.seg1 = 8'hFF;
        m.an1  = 1'b1;
        m.fs1  = 1'b0;
        m.chk1 = 1'b1;
        return m;
    endfunction

    // Expected outputs after edge n of an enabled scan (n=0 is the snapshot).
    function automatic exp_t model(input int n, input logic [3:0][7:0] segs, input logic chk1);
        exp_t m;
        int   pos;
        int   dig;
        pos    = n % 4;
        dig    = (n / 4) % 4;
        m.fs   = (n % 16 == 0);
        m.fs1  = (n % 4 == 0);
        m.chk1 = chk1;
        if (pos < DC) begin
            m.seg  = 8'hFF;
            m.an   = 4'hF;
            m.seg1 = 8'hFF;
            m.an1  = 1'b1;
        end else begin
            m.an      = 4'hF;
            m.an[dig] = 1'b0;
            m.seg     = segs[dig];
            m.an1     = 1'b0;
            m.seg1    = segs[0];
        end
        return m;
    endfunction

    task automatic tick(input exp_t e, input string name);
        exp_t got;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check(name, 32'({seg_n, an_n, frame_start}), 32'({got.seg, got.an, got.fs}));
        if (got.chk1) begin
            check({name, " 1dig"}, 32'({seg1_n, an1_n, fs1}), 32'({got.seg1, got.an1, got.fs1}));
        end
    endtask

    task automatic run(input int n0, input int cnt, input logic [3:0][7:0] segs,
                       input string tag, input logic chk1);
        for (int k = 0; k < cnt; k++) begin
            tick(model(n0 + k, segs, chk1), $sformatf("%s n=%0d", tag, n0 + k));
        end
    endtask

    localparam logic [3:0][7:0] S3210 = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
    localparam logic [3:0][7:0] SFFFF = {8'h8E, 8'h8E, 8'h8E, 8'h8E};
    localparam logic [3:0][7:0] S7654 = {8'h78, 8'h82, 8'h12, 8'h99};

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [3:0][7:0] S0050 = {8'hFF, 8'hFF, 8'h92, 8'hC0};
    localparam logic [3:0][7:0] S0000 = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
    localparam logic [3:0][7:0] S0100 = {8'hFF, 8'hF9, 8'hC0, 8'hC0};
    localparam logic [3:0][7:0] S0000D = {8'hFF, 8'h40, 8'hC0, 8'hC0};
`else
    localparam logic [3:0][7:0] S0050 = {8'hC0, 8'hC0, 8'h92, 8'hC0};
    localparam logic [3:0][7:0] S0000 = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
    localparam logic [3:0][7:0] S0100 = {8'hC0, 8'hF9, 8'hC0, 8'hC0};
    localparam logic [3:0][7:0] S0000D = {8'hC0, 8'h40, 8'hC0, 8'hC0};
`endif

    vec_t vecs[10];

    initial begin
        int fs_cnt;

        vecs[0] = '{16'h3210, 4'b0000, 4'b0000, S3210};
        vecs[1] = '{16'h8888, 4'b0010, 4'b0001, {8'h80, 8'h80, 8'hFF, 8'h00}};
        vecs[2] = '{16'hFFFF, 4'b0000, 4'b0000, SFFFF};
        vecs[3] = '{16'h7654, 4'b0000, 4'b1010, S7654};
        vecs[4] = '{16'hBA98, 4'b1000, 4'b0000, {8'hFF, 8'h88, 8'h90, 8'h80}};
        vecs[5] = '{16'hFEDC, 4'b0000, 4'b1111, {8'h0E, 8'h06, 8'h21, 8'h46}};
        vecs[6] = '{16'h0050, 4'b0000, 4'b0000, S0050};
        vecs[7] = '{16'h0000, 4'b0000, 4'b0000, S0000};
        vecs[8] = '{16'h0100, 4'b0000, 4'b0000, S0100};
        vecs[9] = '{16'h0000, 4'b0000, 4'b0100, S0000D};

        // Reset held with en=1: rst wins, outputs stay off.
        rst   = 1'b1;
        en    = 1'b1;
        data  = 16'h3210;
        blank = 4'h0;
        dp    = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick(off_exp(), $sformatf("reset hold %0d", k));
        end

        // Release: first frame loads at once, frame_start pulses once per frame.
        rst    = 1'b0;
        fs_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            tick(model(k, S3210, 1'b1), $sformatf("post-reset n=%0d", k));
            fs_cnt += int'(frame_start);
        end
        check("frame_start count in first frame", 32'(fs_cnt), 32'd1);
        run(16, 4, S3210, "second frame", 1'b1);

        // Table of full frames, each started from a fresh enable.
        for (int i = 0; i < 10; i++) begin
            en    = 1'b0;
            data  = vecs[i].data;
            blank = vecs[i].blank;
            dp    = vecs[i].dp;
            tick(off_exp(), $sformatf("vec%0d restart", i));
            en = 1'b1;
            run(0, 16, vecs[i].seg, $sformatf("vec%0d", i), 1'b1);
        end

        // Tear-free snapshot: input change in slot 1 waits for the next frame.
        en    = 1'b0;
        data  = 16'h3210;
        blank = 4'h0;
        dp    = 4'h0;
        tick(off_exp(), "snap restart");
        en = 1'b1;
        run(0, 6, S3210, "snap", 1'b1);
        data = 16'hFFFF;
        run(6, 10, S3210, "snap held", 1'b0);
        run(16, 16, SFFFF, "snap new", 1'b1);

        // Enable dropped mid-slot 2, then raised with new inputs.
        en   = 1'b0;
        data = 16'h3210;
        tick(off_exp(), "en restart");
        en = 1'b1;
        run(0, 10, S3210, "pre-drop", 1'b1);
        en   = 1'b0;
        data = 16'h7654;
        dp   = 4'b1010;
        tick(off_exp(), "en drop");
        tick(off_exp(), "en low");
        en = 1'b1;
        run(0, 16, S7654, "en rise", 1'b1);

        // Reset mid-slot with en held high.
        run(16, 6, S7654, "pre-rst", 1'b1);
        rst = 1'b1;
        tick(off_exp(), "rst mid-slot");
        tick(off_exp(), "rst held");
        rst  = 1'b0;
        data = 16'h3210;
        dp   = 4'h0;
        run(0, 8, S3210, "post-rst", 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment scanner that drives the board `seg_n`/`an_n` outputs from a packed hex value supplied by the core's debug/readout path.
- Generalises the fixed 8-digit display drive:
  - configurable digit count and refresh rate;
  - anti-ghosting dead time;
  - per-digit blank and decimal-point masks;
  - tear-free frame snapshot.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- DIV_BITS, 17, each digit slot lasts 2^DIV_BITS clk cycles.
- DEAD_CYCLES, 4, cycles at the start of each slot with all anodes off; must be < 2^DIV_BITS.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  display enable; low blanks the display and restarts the scan.
- data  in  4*NUM_DIGITS  hex nibbles; digit i = data[4i+3:4i].
- blank  in  NUM_DIGITS  bit i high forces digit i dark.
- dp  in  NUM_DIGITS  bit i high lights the decimal point of digit i.
- seg_n  out  8  active-low segments: bit7 = dp, bits6..0 = g,f,e,d,c,b,a.
- an_n  out  NUM_DIGITS  active-low anode select, at most one bit low.
- frame_start  out  1  one-cycle pulse when the shadow registers load.

Behaviour:
- Reset (rst=1 at a clk edge), all synchronous:
  - div_cnt = 0, digit = 0;
  - shadow data/blank/dp = 0;
  - seg_n = 8'hFF, an_n = all ones, frame_start = 0.
- Counters, with en=1:
  - div_cnt increments every cycle and wraps 2^DIV_BITS-1 -> 0.
  - When div_cnt wraps, digit increments and wraps NUM_DIGITS-1 -> 0.
- en=0:
  - div_cnt and digit are forced to 0.
  - Next-cycle outputs are seg_n = 8'hFF, an_n = all ones, frame_start = 0.
- Snapshot:
  - Condition: en=1 and div_cnt==0 and digit==0.
  - On that cycle, data/blank/dp load into shadow registers and frame_start pulses on the next cycle.
  - Input changes mid-frame have no effect until the next frame start.
  - First frame after reset or after en rises loads immediately, because the counters sit at 0.
- Output pipeline:
  - Outputs are registered. Values at cycle t+1 derive from the counters and shadow registers at cycle t.
  - Dead time: if div_cnt < DEAD_CYCLES, an_n = all ones and seg_n = 8'hFF.
  - Otherwise an_n has bit[digit] low and the rest high.
  - seg_n = {~shadow_dp[digit], hex7(shadow nibble)}.
  - If shadow_blank[digit]=1, seg_n = 8'hFF with the anode still asserted. The dp is also suppressed.
- hex7, active-low {g..a}:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - Example: digit 0, no dp -> seg_n = 8'hC0.
- Boundaries:
  - NUM_DIGITS=1: digit stays 0.
  - rst asserted mid-slot: reset values appear on the outputs in the cycle after the rst edge.
  - rst has priority over en.
  - Simultaneous snapshot and digit wrap is the normal frame boundary; there is no special case.
- Widths: the digit counter is max(1,$clog2(NUM_DIGITS)) bits; comparisons are against NUM_DIGITS-1.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- When defined, leading-zero blanking applies at snapshot time:
  - Scan from digit NUM_DIGITS-1 down to digit 1.
  - Each digit whose nibble is 0 and whose dp bit is 0 is treated as blank, until the first nonzero nibble or set dp.
  - Digit 0 is never auto-blanked.
  - The blank input is still ORed in.
- When undefined, only the blank input blanks digits.

Test Plan (NUM_DIGITS=4, DIV_BITS=2, DEAD_CYCLES=1 unless noted):
- Reset: hold rst 3 cycles with en=1 -> seg_n=8'hFF, an_n=4'hF, frame_start=0 throughout. Release -> frame_start pulses exactly once, 1 cycle after the first counter-zero cycle.
- Scan: data=16'h3210, dp=0, blank=0 -> each 4-cycle slot gives 1 dead cycle (an_n=F, seg_n=FF) then 3 cycles with:
  - slot 0: an_n=E, seg_n=C0;
  - slot 1: an_n=D, seg_n=F9;
  - slot 2: an_n=B, seg_n=A4;
  - slot 3: an_n=7, seg_n=B0.
  - Repeats every 16 cycles.
- Snapshot: change data to 16'hFFFF during slot 1 -> slots 2 and 3 still show 2 and 3. The next frame shows F (seg_n=8E) on all digits.
- Masks: blank=4'b0010, dp=4'b0001, data=16'h8888 -> digit0 seg_n=00, digit1 an_n=D with seg_n=FF, digits 2 and 3 seg_n=80.
- Enable: drop en mid-slot 2 -> next cycle all outputs are off. Raise en -> scan restarts at digit 0 with a new snapshot.
- SEG_LEADING_ZERO_BLANK_EN defined: data=16'h0050 -> digit3 dark, digit2 dark, digit1 seg_n=92, digit0 seg_n=C0. data=16'h0000 -> only digit0 lit (C0).
